cordic_phase_gen: RTL and testbench
===================================

CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 Parameter PHASE_W, default 32: width of the angle datapath; SHALL match the CORDIC angle input width.
REQ-002 Parameter CNT_W, default 16: width of the sample counter.
REQ-003 Port clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; the block is in reset when reset==0 at a rising edge.
REQ-005 Port start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
REQ-006 Port phase_init  input  PHASE_W signed  first angle of the burst, Q.14 radians.
REQ-007 Port phase_step  input  PHASE_W signed  per-sample angle increment, Q.14 radians.
REQ-008 Port num_samples  input  CNT_W unsigned  number of angles in the burst.
REQ-009 Port hold  input  1  stall; while high in RUN, no sample is emitted.
REQ-010 Port valid_out  output  1  rad_out is a valid sample; connects to CORDIC valid_in.
REQ-011 Port rad_out  output  PHASE_W signed  angle sample, Q.14; connects to CORDIC rad_in.
REQ-012 Port busy  output  1  high in RUN and DONE.
REQ-013 Port done  output  1  one-cycle pulse after the last sample.
REQ-014 Port cfg_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-015 Angle format SHALL be Q.14 signed: PI=51472, TWO_PI=102944; the legal range is [-PI, PI).
REQ-016 FSM states SHALL be IDLE, RUN and DONE; DONE SHALL always return to IDLE after one cycle.
REQ-017 In IDLE with start=1, the request SHALL be rejected (cfg_err=1 next cycle, stay IDLE) if num_samples==0, phase_init outside [-PI,PI), or |phase_step|>PI.
REQ-018 An accepted start SHALL load phase_reg=phase_init, phase_step_reg=phase_step and count=num_samples, then enter RUN.
REQ-019 In RUN with hold=0, the block SHALL register valid_out=1 and rad_out=phase_reg, update phase_reg=wrap(phase_reg+phase_step_reg), and decrement count.
REQ-020 wrap() SHALL compute the sum at PHASE_W+1 bits, subtract TWO_PI if the sum is >= PI, and add TWO_PI if the sum is < -PI; a single correction suffices given REQ-017.
REQ-021 In RUN with hold=1, the block SHALL register valid_out=0, and phase_reg and count SHALL be unchanged.
REQ-022 Latency: the first sample SHALL appear on valid_out the cycle after the start is accepted; with hold low, N samples SHALL occur on N consecutive cycles.
REQ-023 When the last sample is emitted, the FSM SHALL enter DONE, and done SHALL be high in the cycle after the last valid_out.
REQ-024 start SHALL be ignored in RUN and DONE; configuration inputs SHALL be sampled only at acceptance.
REQ-025 valid_out SHALL be 0 in IDLE and DONE; rad_out SHALL hold its last value when valid_out=0.

Reset
REQ-026 reset==0 at an edge SHALL force IDLE and set valid_out=0, rad_out=0, busy=0, done=0, cfg_err=0, phase_reg=0 and count=0, including mid-burst; no further samples SHALL follow.

Structure
REQ-027 The shared package cordic_pkg SHALL hold QUANT_BITS=14, PI, TWO_PI, HALF_PI=25736, the width constants and the FSM state enum.
REQ-028 A combinational sub-module, phase_wrap_add, SHALL implement wrap(a+b).

Verification
REQ-029 Basic burst: init=0, step=12868, N=8 -> rad_out = 0, 12868, 25736, 38604, -51472, -38604, -25736, -12868 on 8 consecutive cycles; done high in the next cycle.
REQ-030 Negative wrap: init=-51472, step=-25736, N=3 -> rad_out = -51472, 25736, 0.
REQ-031 Hold: same as REQ-029 with hold high for 2 cycles after the 3rd sample -> 2-cycle valid gap, then the sequence resumes at 38604 with no sample lost or repeated.
REQ-032 Rejected starts: start with N=0, then step=60000, then init=51472 -> cfg_err pulses each time, valid_out and busy stay 0.
REQ-033 Reset mid-burst: reset low during the 4th sample of REQ-029 -> all outputs 0 the next cycle; a new start afterwards runs normally from its own init.
REQ-034 Busy start: start pulse with different config during RUN -> ignored; the original sequence completes unchanged.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared Q.14 angle constants, widths and FSM state type
package cordic_pkg;

  localparam int QUANT_BITS  = 14;
  localparam int PHASE_W_DEF = 32;
  localparam int CNT_W_DEF   = 16;

  // Angles are radians scaled by 2**QUANT_BITS
  localparam int PI      = 51472;
  localparam int TWO_PI  = 102944;
  localparam int HALF_PI = 25736;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/phase_wrap_add.sv
// rtl/phase_wrap_add.sv - combinational a+b folded back into [-PI, PI)
module phase_wrap_add
  import cordic_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic signed [PHASE_W-1:0] a_i,
  input  logic signed [PHASE_W-1:0] b_i,
  output logic signed [PHASE_W-1:0] sum_o
);

  localparam logic signed [PHASE_W:0] PI_X     = (PHASE_W+1)'(PI);
  localparam logic signed [PHASE_W:0] TWO_PI_X = (PHASE_W+1)'(TWO_PI);

  logic signed [PHASE_W:0] sum_w;
  logic signed [PHASE_W:0] corr_w;

  // One extra bit keeps the raw sum exact; both operands are within [-PI, PI],
  // so a single +/- TWO_PI correction always lands back in range.
  always_comb begin
    sum_w  = {a_i[PHASE_W-1], a_i} + {b_i[PHASE_W-1], b_i};
    corr_w = sum_w;
    if (sum_w >= PI_X) begin
      corr_w = sum_w - TWO_PI_X;
    end else if (sum_w < -PI_X) begin
      corr_w = sum_w + TWO_PI_X;
    end
  end

  assign sum_o = corr_w[PHASE_W-1:0];

endmodule

// File: rtl/cordic_phase_gen.sv
// rtl/cordic_phase_gen.sv - burst generator of wrapped Q.14 angles for a CORDIC core
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [PHASE_W-1:0] phase_init,
  input  logic signed [PHASE_W-1:0] phase_step,
  input  logic        [CNT_W-1:0]   num_samples,
  input  logic                      hold,
  output logic                      valid_out,
  output logic signed [PHASE_W-1:0] rad_out,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam logic signed [PHASE_W-1:0] PI_W = PHASE_W'(PI);

  state_e                    state_q, state_d;
  logic signed [PHASE_W-1:0] phase_q, phase_d;
  logic signed [PHASE_W-1:0] step_q, step_d;
  logic        [CNT_W-1:0]   count_q, count_d;
  logic                      valid_q, valid_d;
  logic signed [PHASE_W-1:0] rad_q, rad_d;
  logic                      done_q, done_d;
  logic                      cfg_err_q, cfg_err_d;

  logic signed [PHASE_W-1:0] phase_next;
  logic                      cfg_bad;

  phase_wrap_add #(
    .PHASE_W (PHASE_W)
  ) u_wrap (
    .a_i   (phase_q),
    .b_i   (step_q),
    .sum_o (phase_next)
  );

  // A start is refused when the burst is empty, the first angle is outside
  // [-PI, PI), or the step is large enough to need more than one wrap.
  always_comb begin
    cfg_bad = (num_samples == '0)
           || (phase_init < -PI_W) || (phase_init >= PI_W)
           || (phase_step >  PI_W) || (phase_step < -PI_W);
  end

  // Next-state logic: accept/reject in IDLE, emit or stall in RUN, pulse done.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    rad_d     = rad_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            phase_d = phase_init;
            step_d  = phase_step;
            count_d = num_samples;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!hold) begin
          valid_d = 1'b1;
          rad_d   = phase_q;
          phase_d = phase_next;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      rad_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      rad_q     <= rad_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign valid_out = valid_q;
  assign rad_out   = rad_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb/tb_cordic_phase_gen.sv - self-checking bench for cordic_phase_gen
module tb_cordic_phase_gen;

  localparam int     PW     = 32;
  localparam int     CW     = 16;
  localparam longint PI     = 51472;
  localparam longint TWO_PI = 102944;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 hold  = 1'b0;
  logic signed [PW-1:0] phase_init = '0;
  logic signed [PW-1:0] phase_step = '0;
  logic        [CW-1:0] num_samples = '0;
  logic                 valid_out;
  logic signed [PW-1:0] rad_out;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;

  int vectors     = 0;
  int miscompares = 0;

  cordic_phase_gen #(
    .PHASE_W (PW),
    .CNT_W   (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .phase_init  (phase_init),
    .phase_step  (phase_step),
    .num_samples (num_samples),
    .hold        (hold),
    .valid_out   (valid_out),
    .rad_out     (rad_out),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // k-th angle of a burst: init + k*step reduced modulo 2*PI into [-PI, PI)
  function automatic longint ref_angle(input longint init, input longint step, input int k);
    longint a;
    a = init + longint'(k) * step + PI;
    a = a % TWO_PI;
    if (a < 0) a += TWO_PI;
    return a - PI;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_rad"}, rad_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // hold_mode: 0 none, 1 random, 2 two cycles after the third sample
  task automatic run_burst(input longint init, input longint step, input int n,
                           input int hold_mode, input int reset_at, input bit busy_start);
    int     k;
    int     hold_left;
    int     budget;
    bit     held;
    bit     h;
    longint last_rad;
    k = 0; hold_left = 0; held = 0;
    phase_init  = PW'(init);
    phase_step  = PW'(step);
    num_samples = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_cfg_err", cfg_err, 0);
    check("accept_valid", valid_out, 0);
    last_rad = rad_out;
    budget = 4 * n + 20;
    while (k < n && budget > 0) begin
      budget--;
      h = 1'b0;
      if (hold_mode == 1) h = ($urandom_range(0, 3) == 0);
      if (hold_mode == 2 && k == 3 && !held) begin
        hold_left = 2;
        held = 1'b1;
      end
      if (hold_left > 0) begin
        h = 1'b1;
        hold_left--;
      end
      hold = h;
      if (busy_start && k == 2) begin
        start       = 1'b1;
        phase_init  = PW'(1000);
        phase_step  = PW'(7);
        num_samples = CW'(3);
      end
      tick();
      start = 1'b0;
      hold  = 1'b0;
      check("run_valid", valid_out, !h);
      check("run_done", done, 0);
      if (h) begin
        check("hold_rad", rad_out, last_rad);
      end else begin
        check("sample", rad_out, ref_angle(init, step, k));
        k++;
        last_rad = rad_out;
        if (reset_at >= 0 && k == reset_at) begin
          reset = 1'b0;
          tick();
          reset = 1'b1;
          check_all_zero("mid_reset");
          repeat (3) begin
            tick();
            check("post_reset_valid", valid_out, 0);
            check("post_reset_busy", busy, 0);
          end
          return;
        end
      end
    end
    check("sample_count", k, n);
    tick();
    check("end_done", done, 1);
    check("end_valid", valid_out, 0);
    check("end_busy", busy, 0);
    tick();
    check("end_done_clear", done, 0);
  endtask

  task automatic try_reject(input string tag, input longint init, input longint step, input int n);
    phase_init  = PW'(init);
    phase_step  = PW'(step);
    num_samples = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_cfg_err"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, valid_out, 0);
    tick();
    check({tag, "_cfg_err_clear"}, cfg_err, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_valid_after"}, valid_out, 0);
  endtask

  initial begin
    longint init;
    longint step;
    reset = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("idle");

    run_burst(0, 12868, 8, 0, -1, 1'b0);
    run_burst(-51472, -25736, 3, 0, -1, 1'b0);
    run_burst(0, 12868, 8, 2, -1, 1'b0);

    try_reject("rej_n0", 0, 12868, 0);
    try_reject("rej_step", 0, 60000, 4);
    try_reject("rej_init", 51472, 100, 4);
    try_reject("rej_step_neg", 0, -51473, 4);
    try_reject("rej_init_low", -51473, 0, 2);

    run_burst(0, 12868, 8, 0, 4, 1'b0);
    run_burst(1234, -5000, 5, 0, -1, 1'b0);
    run_burst(0, 12868, 8, 0, -1, 1'b1);

    run_burst(-51472, 51472, 4, 0, -1, 1'b0);
    run_burst(51471, -51472, 4, 0, -1, 1'b0);
    run_burst(25736, 0, 1, 0, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      init = longint'($urandom_range(0, 102943)) - PI;
      step = longint'($urandom_range(0, 102944)) - PI;
      if ($urandom_range(0, 5) == 0) begin
        try_reject("rej_rand", init, PI + longint'($urandom_range(1, 1000)), 3);
      end
      run_burst(init, step, int'($urandom_range(1, 24)), 1, -1, 1'(($urandom_range(0, 1))));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
